// File: rtl/edge_list_reader.sv
// edge_list_reader: walks a graph edge list held in dmem and streams the
// edges out one per handshake. Word BASE holds the header {N, E, src, dst};
// the words after it hold two 16-bit {u, v} edges each, high half first.
// Optional feature macro: EDGE_READER_RANGE_CHECK_EN. When defined, `err`
// flags any header endpoint or emitted edge endpoint that is >= N.
module edge_list_reader #(
  parameter logic [15:0] BASE   = 16'h0000,
  parameter int          DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        num_nodes,
  output logic [7:0]        num_edges,
  output logic [7:0]        src_node,
  output logic [7:0]        dst_node,
  output logic [15:0]       mem_a,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  output logic              e_valid,
  input  logic              e_ready,
  output logic [7:0]        e_u,
  output logic [7:0]        e_v,
  output logic              e_last,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    FETCH   = 3'd2,
    EMIT_HI = 3'd3,
    EMIT_LO = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        idx;
  logic [7:0]        idx_inc;
  logic [DATA_W-1:0] word_buf;
  logic              hs;
  logic              last_edge;

  // The edge index after the current one; E <= 255 so it never overflows.
  assign idx_inc   = idx + 8'd1;
  assign hs        = e_valid && e_ready;
  assign last_edge = (idx_inc == num_edges);

  // This block only ever reads dmem.
  assign mem_wd = '0;
  assign mem_we = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic for the walk.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = HDR;
        else       state_nxt = IDLE;
      end
      HDR: begin
        if (mem_rd[23:16] == 8'd0) state_nxt = DONE;
        else                       state_nxt = FETCH;
      end
      FETCH: state_nxt = EMIT_HI;
      EMIT_HI: begin
        if (hs) state_nxt = last_edge ? DONE : EMIT_LO;
        else    state_nxt = EMIT_HI;
      end
      EMIT_LO: begin
        if (hs) state_nxt = last_edge ? DONE : FETCH;
        else    state_nxt = EMIT_LO;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: address, stream and status signals from state and buffer.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    e_valid = 1'b0;
    mem_a   = BASE;
    e_u     = word_buf[31:24];
    e_v     = word_buf[23:16];
    case (state)
      HDR: begin
        busy  = 1'b1;
        mem_a = BASE;
      end
      FETCH: begin
        busy  = 1'b1;
        mem_a = BASE + 16'd1 + {9'd0, idx[7:1]};
      end
      EMIT_HI: begin
        busy    = 1'b1;
        e_valid = 1'b1;
      end
      EMIT_LO: begin
        busy    = 1'b1;
        e_valid = 1'b1;
        e_u     = word_buf[15:8];
        e_v     = word_buf[7:0];
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
    e_last = e_valid && last_edge;
  end

  // Datapath: edge index, header latches and the fetched word buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 8'd0;
      word_buf  <= '0;
      num_nodes <= 8'd0;
      num_edges <= 8'd0;
      src_node  <= 8'd0;
      dst_node  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) idx <= 8'd0;
        end
        HDR: begin
          num_nodes <= mem_rd[31:24];
          num_edges <= mem_rd[23:16];
          src_node  <= mem_rd[15:8];
          dst_node  <= mem_rd[7:0];
        end
        FETCH: word_buf <= mem_rd;
        EMIT_HI, EMIT_LO: begin
          if (hs) idx <= idx_inc;
        end
        default: idx <= idx;
      endcase
    end
  end

`ifdef EDGE_READER_RANGE_CHECK_EN
  // Sticky range flag: cleared by a new walk, set by any endpoint >= N.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      err <= 1'b0;
    end else if (state == HDR &&
                 (mem_rd[15:8] >= mem_rd[31:24] || mem_rd[7:0] >= mem_rd[31:24])) begin
      err <= 1'b1;
    end else if (hs && (e_u >= num_nodes || e_v >= num_nodes)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
